// File: rtl/snn_in_loader_if.sv
// snn_in_loader_if: pattern-side input stream bundle for the SNN loader.
// The pattern drives through master; the loader samples through slave.
interface snn_in_loader_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic [DW-1:0] Img;
  logic [DW-1:0] Kernel;
  logic [DW-1:0] Weight;
  logic [1:0]    Opt;

  modport master (
    output in_valid, Img, Kernel, Weight, Opt
  );
  modport slave (
    input in_valid, Img, Kernel, Weight, Opt
  );
endinterface

// File: rtl/snn_in_loader.sv
// snn_in_loader: buffers one image/kernel/weight frame, hands it to the core.
// SNN_LOADER_CG_EN adds registered per-bank clock-gate enables.
module snn_in_loader #(
  parameter int DW      = 32,
  parameter int IMG_DIM = 6,
  parameter int KER_DIM = 3,
  parameter int NUM_CH  = 3,
  parameter int NUM_IMG = 2,
  parameter int NUM_W   = 4,
  localparam int IMG_WORDS = IMG_DIM*IMG_DIM*NUM_CH*NUM_IMG,
  localparam int KER_WORDS = KER_DIM*KER_DIM*NUM_CH,
  localparam int AW  = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1,
  localparam int KAW = (KER_WORDS > 1) ? $clog2(KER_WORDS) : 1,
  localparam int WAW = (NUM_W > 1) ? $clog2(NUM_W) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cg_en,
  snn_in_loader_if.slave        s,
  input  logic                  core_ready,
  input  logic                  core_done,
  input  logic [AW-1:0]         img_raddr,
  output logic [DW-1:0]         img_rdata,
  input  logic [KAW-1:0]        ker_raddr,
  output logic [DW-1:0]         ker_rdata,
  input  logic [WAW-1:0]        wgt_raddr,
  output logic [DW-1:0]         wgt_rdata,
  output logic [1:0]            opt_q,
  output logic                  core_start,
  output logic                  busy,
  output logic                  err,
  output logic                  ker_gate_en,
  output logic                  img_gate_en
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_e;

  localparam logic [AW-1:0] LAST  = AW'(IMG_WORDS-1);
  localparam logic [AW:0]   K_LIM = (AW+1)'(KER_WORDS);
  localparam logic [AW:0]   W_LIM = (AW+1)'(NUM_W);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  logic [1:0]    opt_d;

  logic [DW-1:0] img_mem [IMG_WORDS];
  logic [DW-1:0] ker_mem [KER_WORDS];
  logic [DW-1:0] wgt_mem [NUM_W];

  logic          take;
  logic [AW-1:0] waddr;
  logic          ker_gate;
  logic          img_gate;

  assign take  = rst_n && s.in_valid
              && (state_q == IDLE || state_q == LOAD);
  assign waddr = (state_q == LOAD) ? cnt_q : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    opt_d   = opt_q;
    unique case (state_q)
      IDLE: begin
        if (s.in_valid) begin
          opt_d   = s.Opt;
          cnt_d   = AW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!s.in_valid) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          cnt_d = '0;
          if (core_ready) begin
            start_d = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = WAIT;
          end
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      WAIT: begin
        err_d = s.in_valid;
        if (core_ready) begin
          start_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // a word arriving with core_done is dropped, never a new frame
        err_d = s.in_valid;
        if (core_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      opt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      err_q   <= err_d;
      opt_q   <= opt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (take && img_gate)
      img_mem[waddr] <= s.Img;
    if (take && ker_gate && ({1'b0, waddr} < K_LIM))
      ker_mem[waddr[KAW-1:0]] <= s.Kernel;
    if (take && ker_gate && ({1'b0, waddr} < W_LIM))
      wgt_mem[waddr[WAW-1:0]] <= s.Weight;
  end

`ifdef SNN_LOADER_CG_EN
  logic ker_gate_q, ker_gate_d;
  logic img_gate_q, img_gate_d;

  assign ker_gate_d = !cg_en || state_q == IDLE
                   || (state_q == LOAD && {1'b0, cnt_q} < K_LIM);
  assign img_gate_d = !cg_en || state_q == IDLE || state_q == LOAD;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ker_gate_q <= 1'b1;
      img_gate_q <= 1'b1;
    end else begin
      ker_gate_q <= ker_gate_d;
      img_gate_q <= img_gate_d;
    end
  end

  assign ker_gate = ker_gate_q;
  assign img_gate = img_gate_q;
`else
  logic unused_cg;
  assign unused_cg = cg_en;
  assign ker_gate  = 1'b1;
  assign img_gate  = 1'b1;
`endif

  assign img_rdata   = img_mem[img_raddr];
  assign ker_rdata   = ker_mem[ker_raddr];
  assign wgt_rdata   = wgt_mem[wgt_raddr];
  assign core_start  = start_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE);
  assign ker_gate_en = ker_gate;
  assign img_gate_en = img_gate;

endmodule

// File: doc/snn_in_loader.md
Name: snn_in_loader

Overview:
- Parametrised input-stream loader for the SNN datapath. It sits between the pattern-side ports (in_valid, Img, Kernel, Weight, Opt, cg_en) and the compute core.
- It counts and buffers one frame of image, kernel and weight words into register banks, then hands the frame to the core with a start/done handshake.
- It generalises the fixed 6x6x3x2 / 3x3x3 / 2x2 input format to arbitrary dimensions and channel/image counts.
- It provides per-bank clock-gate enables for the core.

Parameters:
- DW, 32, data word width (IEEE-754 single by default; the loader treats words as opaque bits).
- IMG_DIM, 6, image side length.
- KER_DIM, 3, kernel side length.
- NUM_CH, 3, channels per image (equals the kernel count).
- NUM_IMG, 2, images per frame.
- NUM_W, 4, weight words per frame.
- Derived, not overridable:
  - IMG_WORDS = IMG_DIM*IMG_DIM*NUM_CH*NUM_IMG (216)
  - KER_WORDS = KER_DIM*KER_DIM*NUM_CH (27)
  - AW = clog2(IMG_WORDS)

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- cg_en  in  1  clock-gating request from pattern; sampled every cycle.
- in_valid  in  1  input stream valid.
- Img  in  DW  image word.
- Kernel  in  DW  kernel word; valid during the first KER_WORDS in_valid cycles.
- Weight  in  DW  weight word; valid during the first NUM_W in_valid cycles.
- Opt  in  2  mode; valid on the first in_valid cycle only.
- core_ready  in  1  core idle and able to accept a frame.
- core_done  in  1  one-cycle pulse: core has released the buffers.
- img_raddr  in  AW  image bank read address.
- img_rdata  out  DW  combinational read of image bank.
- ker_raddr  in  clog2(KER_WORDS)  kernel bank read address.
- ker_rdata  out  DW  combinational read.
- wgt_raddr  in  clog2(NUM_W)  weight bank read address.
- wgt_rdata  out  DW  combinational read.
- opt_q  out  2  latched Opt.
- core_start  out  1  one-cycle start pulse.
- busy  out  1  high from the first accepted word until core_done.
- err  out  1  one-cycle protocol-error pulse.
- ker_gate_en  out  1  kernel/weight bank clock-gate enable.
- img_gate_en  out  1  image bank clock-gate enable.

Behaviour:
- Reset (rst_n low at a posedge):
  - state=IDLE; counters=0.
  - core_start=0, busy=0, err=0, opt_q=0.
  - gate enables=1.
  - Bank contents are not reset.
  - A reset mid-LOAD or mid-HOLD discards the frame; no core_start is issued afterwards.
- States: IDLE, LOAD, WAIT, HOLD.
- IDLE:
  - in_valid=1 → write Img to img[0], Kernel to ker[0], Weight to wgt[0]; opt_q<=Opt; cnt<=1; go to LOAD.
  - busy rises in the same cycle the state changes to LOAD.
- LOAD: each in_valid cycle writes
  - img[cnt];
  - ker[cnt] if cnt<KER_WORDS;
  - wgt[cnt] if cnt<NUM_W;
  - then cnt++.
- Last image word accepted (cnt==IMG_WORDS-1):
  - core_ready=1 that cycle → core_start pulses the next cycle and state goes to HOLD.
  - Otherwise → go to WAIT.
- WAIT: core_start pulses one cycle after core_ready is first seen high; then go to HOLD.
- HOLD: on core_done → IDLE next cycle; busy falls with the state change.
- Boundary and error conditions:
  - Stream gap: in_valid=0 in LOAD before IMG_WORDS words → err pulse next cycle, state=IDLE, cnt=0, no core_start.
  - Overrun: in_valid=1 in WAIT or HOLD → word ignored, banks unchanged, err pulse next cycle, state unchanged.
  - core_done outside HOLD is ignored.
  - core_done coincident with in_valid in HOLD → err pulse; the word is dropped and is not taken as a new frame.
  - Back-to-back frames: a new frame may start on the first IDLE cycle after HOLD.
- Read ports are combinational and valid in all states. Reads in HOLD return the stored frame.
- Latency: the first core_start is exactly 1 cycle after the last image word when core_ready=1.

Optional Feature:
- Macro: SNN_LOADER_CG_EN.
- Defined:
  - ker_gate_en = !cg_en || (state==LOAD && cnt<KER_WORDS) || state==IDLE.
  - img_gate_en = !cg_en || state==IDLE || state==LOAD.
  - Both enables are registered (1-cycle lag from state) and are 1 during reset.
  - Bank writes are additionally qualified by their gate enable.
- Undefined:
  - Both enables are constant 1.
  - cg_en is unused (left unconnected internally).
  - Functionality is otherwise identical.

Test Plan:
- Nominal frame, defaults, core_ready=1: stream 216 words with Img=i, Kernel=0x1000+i, Weight=0x2000+i, Opt=2'b10 on cycle 0 → core_start one cycle after word 215.
  - Readback: img[215]=215, ker[26]=0x101A, wgt[3]=0x2003, opt_q=2.
  - Kernel/Weight values sent after word 26 and word 3 are not stored.
- Delayed core: core_ready=0 until 10 cycles after the last word → state WAIT, then core_start exactly 1 cycle after core_ready rises; busy stays 1 until core_done.
- Gap: in_valid drops after 100 words → err pulses once, busy=0, no core_start. A following full frame loads correctly.
- Overrun and coincident done: in_valid=1 for 3 cycles in HOLD → 3 err pulses, img[0..2] unchanged. core_done coincident with in_valid → err pulse and IDLE.
- Reset mid-LOAD at word 50 → all outputs at reset values; a new frame then loads from address 0.
- Parameter sweep and clock gating: IMG_DIM=4, NUM_CH=1, NUM_IMG=1, KER_DIM=2, NUM_W=2 → core_start after 16 words, ker[3] stored.
  - With SNN_LOADER_CG_EN and cg_en=1: ker_gate_en=0 from word 5 until IDLE.
